alu_sequencer: RTL
==================

# alu_sequencer

Command sequencer that drives the RAM/ALU/MUX datapath from the initiator side. It accepts write, read and ALU commands over a valid/ready handshake and turns each into the datapath control signals: write enable, addresses, operand addresses, opcode and output select. For reads and ALU operations it waits a fixed latency, captures the datapath's 5-bit output and returns it over a second valid/ready handshake. It sits between any command source (test host, microcode) and the datapath top.

## Interface
- READ_WAIT, 1: cycles from dp_* valid to dp_out valid for a read (sel=0); legal 1..15
- ALU_WAIT, 2: cycles from dp_* valid to dp_out valid for an ALU op (sel=1); legal 1..15

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept
- cmd_kind  in  2  00 write, 01 read, 10 alu, 11 nop
- cmd_addr  in  4  write/read address
- cmd_data  in  4  write data
- cmd_op1, cmd_op2  in  4 each  operand addresses
- cmd_opcode  in  2  ALU opcode, passed through opaquely
- dp_we  out  1  datapath write enable
- dp_data  out  4  datapath write data
- dp_addr  out  4  datapath address
- dp_addrop1, dp_addrop2  out  4 each  operand addresses
- dp_opcode  out  2  ALU opcode
- dp_sel  out  1  0 selects RAM read data, 1 selects ALU result
- dp_out  in  5  datapath result
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  5  captured dp_out
- res_kind  out  1  0 read result, 1 ALU result

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESULT.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register all cmd_* fields and go to ISSUE.
- ISSUE, write: dp_we=1, dp_addr/dp_data driven, then return to IDLE. No result is produced.
- ISSUE, read: dp_sel=0, dp_addr driven. Load the wait counter with READ_WAIT-1, then go to WAIT.
- ISSUE, alu: dp_sel=1, dp_addrop1/2 and dp_opcode driven. Load the wait counter with ALU_WAIT-1, then go to WAIT.
- ISSUE, nop: no datapath change, return to IDLE.
- WAIT: decrement the counter. When the counter is 0, sample dp_out into res_data, set res_kind, and go to RESULT.
- If the wait value is 1, ISSUE goes straight to RESULT, sampling dp_out at the end of ISSUE.
- RESULT: res_valid=1, with res_data/res_kind held stable. On res_ready, go to IDLE.
- dp_addr, dp_data, dp_addrop1/2, dp_opcode and dp_sel keep their last value between commands. dp_we is high only in ISSUE of a write.
- Reset (asynchronous, any state): state=IDLE, counter=0, and every output 0, including cmd_ready. cmd_ready rises on the first clock edge after reset_n deasserts. An in-flight command is discarded with no result.

## Timing
- Command accepted at edge A.
- dp_* valid during cycle A+1.
- Write: dp_we high in cycle A+1 only. cmd_ready is high again in cycle A+2, giving at most 1 write per 2 cycles.
- Read/ALU with N = READ_WAIT or ALU_WAIT: dp_out is sampled at the edge ending cycle A+N, and res_valid rises in cycle A+N+1.
- Result handshake at edge R: res_valid low and cmd_ready high in cycle R+1. No overlap: cmd_ready=0 from A+1 until IDLE is re-entered.
- res_valid must not drop, and res_data must not change, while res_ready=0.
- cmd_* values are ignored outside the accepting cycle.

## Structure
- Package alu_seq_pkg:
  - cmd_kind encoding constants (KIND_WR, KIND_RD, KIND_ALU, KIND_NOP)
  - state enum
  - widths: ADDR_W=4, DATA_W=4, RES_W=5, OPC_W=2
- One sub-module, seq_wait_timer: 4-bit loadable down-counter with a load input and a done flag, instantiated once.
- Everything else is flat in alu_sequencer.

## Test plan
- Reset: hold reset_n=0 for 3 cycles mid-WAIT of an ALU op. All outputs are 0, no res_valid ever appears, and cmd_ready=1 one cycle after release.
- Write: cmd_kind=00, addr=5, data=9 accepted at edge A. dp_we=1, dp_addr=5, dp_data=9 for exactly cycle A+1, and cmd_ready=1 at A+2.
- Read: with a datapath model returning 5'h09 at addr 5 after 1 cycle, cmd_kind=01, addr=5 gives res_valid at A+2, res_data=9, res_kind=0, dp_sel=0.
- ALU: op1=2, op2=3, opcode=01, ALU_WAIT=2, model dp_out=5'h1F at A+2. Expect res_data=5'h1F at A+3, res_kind=1, dp_sel=1, dp_opcode=01.
- Backpressure: hold res_ready=0 for 5 cycles. res_valid and res_data stay stable, cmd_ready stays 0, and a pending cmd_valid is not accepted until the cycle after the result handshake.
- Nop and back-to-back: nop, then write, with cmd_valid held high. Each is accepted on alternate cycles, the nop produces no dp_we and no result.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings and widths for the command sequencer that fronts the RAM/ALU/MUX datapath.
package alu_seq_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int RES_W  = 5;
  localparam int OPC_W  = 2;
  localparam int CNT_W  = 4;

  localparam logic [1:0] KIND_WR  = 2'b00;
  localparam logic [1:0] KIND_RD  = 2'b01;
  localparam logic [1:0] KIND_ALU = 2'b10;
  localparam logic [1:0] KIND_NOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/seq_wait_timer.sv
// Loadable down-counter pacing the datapath result latency; load wins over decrement, no backpressure.
// done flags the last wait cycle so the caller samples on the edge that takes the count to zero.
module seq_wait_timer
  import alu_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Turns write/read/ALU commands into datapath controls; results return READ_WAIT/ALU_WAIT cycles after issue.
// One command in flight: cmd_ready stays low until IDLE, and a result is held until res_ready takes it.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int READ_WAIT = 1,
  parameter int ALU_WAIT  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ADDR_W-1:0] cmd_op1,
  input  logic [ADDR_W-1:0] cmd_op2,
  input  logic [OPC_W-1:0]  cmd_opcode,
  output logic              dp_we,
  output logic [DATA_W-1:0] dp_data,
  output logic [ADDR_W-1:0] dp_addr,
  output logic [ADDR_W-1:0] dp_addrop1,
  output logic [ADDR_W-1:0] dp_addrop2,
  output logic [OPC_W-1:0]  dp_opcode,
  output logic              dp_sel,
  input  logic [RES_W-1:0]  dp_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_kind
);

  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] ALU_LOAD = CNT_W'(ALU_WAIT - 1);

  state_t            state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              dp_we_q, dp_we_d;
  logic [DATA_W-1:0] dp_data_q, dp_data_d;
  logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
  logic [ADDR_W-1:0] dp_op1_q, dp_op1_d;
  logic [ADDR_W-1:0] dp_op2_q, dp_op2_d;
  logic [OPC_W-1:0]  dp_opc_q, dp_opc_d;
  logic              dp_sel_q, dp_sel_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              res_kind_q, res_kind_d;

  logic              tmr_load, tmr_dec, tmr_done;
  logic [CNT_W-1:0]  tmr_load_val;
  logic              is_alu;

  assign is_alu = (kind_q == KIND_ALU);

  seq_wait_timer u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    cmd_ready_d  = cmd_ready_q;
    dp_we_d      = 1'b0;
    dp_data_d    = dp_data_q;
    dp_addr_d    = dp_addr_q;
    dp_op1_d     = dp_op1_q;
    dp_op2_d     = dp_op2_q;
    dp_opc_d     = dp_opc_q;
    dp_sel_d     = dp_sel_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_kind_d   = res_kind_q;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = is_alu ? ALU_LOAD : RD_LOAD;

    case (state_q)
      IDLE: begin
        // Outputs are registered, so datapath controls are loaded on the accepting edge.
        if (cmd_ready_q && cmd_valid) begin
          cmd_ready_d = 1'b0;
          kind_d      = cmd_kind;
          state_d     = ISSUE;
          case (cmd_kind)
            KIND_WR: begin
              dp_we_d   = 1'b1;
              dp_addr_d = cmd_addr;
              dp_data_d = cmd_data;
            end
            KIND_RD: begin
              dp_addr_d = cmd_addr;
              dp_sel_d  = 1'b0;
            end
            KIND_ALU: begin
              dp_op1_d = cmd_op1;
              dp_op2_d = cmd_op2;
              dp_opc_d = cmd_opcode;
              dp_sel_d = 1'b1;
            end
            default: ;
          endcase
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ISSUE: begin
        if ((kind_q == KIND_RD) || is_alu) begin
          if (tmr_load_val == '0) begin
            res_valid_d = 1'b1;
            res_data_d  = dp_out;
            res_kind_d  = is_alu;
            state_d     = RESULT;
          end else begin
            tmr_load = 1'b1;
            state_d  = WAIT;
          end
        end else begin
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          res_valid_d = 1'b1;
          res_data_d  = dp_out;
          res_kind_d  = is_alu;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      kind_q      <= KIND_WR;
      cmd_ready_q <= 1'b0;
      dp_we_q     <= 1'b0;
      dp_data_q   <= '0;
      dp_addr_q   <= '0;
      dp_op1_q    <= '0;
      dp_op2_q    <= '0;
      dp_opc_q    <= '0;
      dp_sel_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_kind_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cmd_ready_q <= cmd_ready_d;
      dp_we_q     <= dp_we_d;
      dp_data_q   <= dp_data_d;
      dp_addr_q   <= dp_addr_d;
      dp_op1_q    <= dp_op1_d;
      dp_op2_q    <= dp_op2_d;
      dp_opc_q    <= dp_opc_d;
      dp_sel_q    <= dp_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_kind_q  <= res_kind_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign dp_we      = dp_we_q;
  assign dp_data    = dp_data_q;
  assign dp_addr    = dp_addr_q;
  assign dp_addrop1 = dp_op1_q;
  assign dp_addrop2 = dp_op2_q;
  assign dp_opcode  = dp_opc_q;
  assign dp_sel     = dp_sel_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_kind   = res_kind_q;

endmodule
